branch_predictor: RTL and testbench

Dynamic conditional-branch predictor for the five-stage RV32I pipeline. The decode-stage lookup port produces the `predicted` bit and target address that the MEM-stage branch resolution logic later checks. The MEM-stage update port takes the resolved outcome back in to train a table of 2-bit saturating counters. The block also keeps saturating performance counters of resolved branches and mispredictions.

---
 rtl/branch_predictor.sv | 133 +++++++++++++
 tb/tb_branch_predictor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic conditional-branch predictor for the five-stage RV32I pipeline.
// Decode asks for a prediction through the lookup port. MEM trains a table of
// 2-bit saturating counters through the update port. Two saturating
// performance counters track resolved branches and mispredictions.
//
// Configuration macro: BRANCH_PREDICTOR_GSHARE_EN
//   defined   -> a global history register is XORed into the lookup index
//                (gshare). History is trained at MEM resolution only.
//   undefined -> the index is the PC bits alone (bimodal).
//
// Parameters:
//   INDEX_BITS           log2 of pattern table depth (legal 2..10, default 6)
//
// Ports:
//   clk                  pipeline clock, rising-edge active
//   rst_n                asynchronous active-low reset
//   i_lookup_valid       decode-stage instruction is a conditional branch
//   i_lookup_pc          PC of the decode-stage instruction
//   i_lookup_offset      sign-extended B-type immediate
//   o_predicted          predict taken (qualified by i_lookup_valid)
//   o_predicted_target   i_lookup_pc + i_lookup_offset (mod 2^32)
//   o_predicted_index    table index used for this lookup
//   i_update_valid       MEM-stage instruction is a resolved conditional branch
//   i_update_taken       resolved outcome
//   i_update_predicted   prediction carried down the pipe with this branch
//   i_update_index       table index carried down the pipe with this branch
//   o_branch_count       resolved branches, saturating
//   o_mispredict_count   mispredicted branches, saturating
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lookup_valid,
    input  logic [31:0]           i_lookup_pc,
    input  logic [31:0]           i_lookup_offset,
    output logic                  o_predicted,
    output logic [31:0]           o_predicted_target,
    output logic [INDEX_BITS-1:0] o_predicted_index,
    input  logic                  i_update_valid,
    input  logic                  i_update_taken,
    input  logic                  i_update_predicted,
    input  logic [INDEX_BITS-1:0] i_update_index,
    output logic [31:0]           o_branch_count,
    output logic [31:0]           o_mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]            r_pht [DEPTH];
    logic [31:0]           r_branch_count;
    logic [31:0]           r_mispredict_count;
    logic [INDEX_BITS-1:0] w_pc_idx;
    logic [INDEX_BITS-1:0] w_idx;
    logic [1:0]            w_cur;
    logic [1:0]            w_next;
    logic                  w_unused_pc_bits;

    // Instructions are word aligned, so PC bits [1:0] carry no information.
    assign w_pc_idx = i_lookup_pc[INDEX_BITS+1:2];
    assign w_unused_pc_bits = ^{i_lookup_pc[31:INDEX_BITS+2], i_lookup_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] r_ghr;

    // History shifts in resolved outcomes only, so it never needs repair on a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (i_update_valid) begin
            r_ghr <= {r_ghr[INDEX_BITS-2:0], i_update_taken};
        end
    end

    assign w_idx = w_pc_idx ^ r_ghr;
`else
    assign w_idx = w_pc_idx;
`endif

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign o_predicted        = i_lookup_valid & r_pht[w_idx][1];
    assign o_predicted_target = i_lookup_pc + i_lookup_offset;
    assign o_predicted_index  = w_idx;

    // Saturating step of the 2-bit counter being trained.
    assign w_cur = r_pht[i_update_index];
    always_comb begin
        w_next = w_cur;
        if (i_update_taken) begin
            if (w_cur != 2'b11) begin
                w_next = w_cur + 2'b01;
            end
        end else begin
            if (w_cur != 2'b00) begin
                w_next = w_cur - 2'b01;
            end
        end
    end

    // Every entry starts weak not-taken so the first taken outcome flips it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else if (i_update_valid) begin
            r_pht[i_update_index] <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (i_update_valid) begin
            if (r_branch_count != 32'hFFFF_FFFF) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if ((i_update_predicted ^ i_update_taken) &&
                (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the predictor table and counters.
module tb_branch_predictor;

   localparam int IB = 6;
   localparam int DEPTH = 64;
   localparam int MASK = 63;
   localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

   logic          clk;
   logic          rst_n;
   logic          lookupValid;
   logic [31:0]   lookupPc;
   logic [31:0]   lookupOffset;
   logic          predicted;
   logic [31:0]   predictedTarget;
   logic [IB-1:0] predictedIndex;
   logic          updateValid;
   logic          updateTaken;
   logic          updatePredicted;
   logic [IB-1:0] updateIndex;
   logic [31:0]   branchCount;
   logic [31:0]   mispredictCount;

   int checks;
   int failures;

   int     modelPht [DEPTH];
   longint modelBranches;
   longint modelMisses;
   int     modelGhr;

   branch_predictor #(.INDEX_BITS(IB)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_lookup_valid     (lookupValid),
      .i_lookup_pc        (lookupPc),
      .i_lookup_offset    (lookupOffset),
      .o_predicted        (predicted),
      .o_predicted_target (predictedTarget),
      .o_predicted_index  (predictedIndex),
      .i_update_valid     (updateValid),
      .i_update_taken     (updateTaken),
      .i_update_predicted (updatePredicted),
      .i_update_index     (updateIndex),
      .o_branch_count     (branchCount),
      .o_mispredict_count (mispredictCount)
   );

   // Free-running clock, rising edge at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Time limit so the run always ends even if something wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: table entries are integers 0..3 with clamped arithmetic.
   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) modelPht[i] = 1;
      modelBranches = 0;
      modelMisses   = 0;
      modelGhr      = 0;
   endtask

   function automatic int modelIndex(input logic [31:0] pc);
      int idx;
      idx = int'(pc / 4) % DEPTH;
      if (idx < 0) idx = idx + DEPTH;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      idx = idx ^ modelGhr;
`endif
      return idx;
   endfunction

   task automatic modelUpdate(input logic taken, input logic pred, input int idx);
      if (taken) modelPht[idx] = (modelPht[idx] == 3) ? 3 : modelPht[idx] + 1;
      else       modelPht[idx] = (modelPht[idx] == 0) ? 0 : modelPht[idx] - 1;
      if (modelBranches < MAXC) modelBranches++;
      if ((pred != taken) && (modelMisses < MAXC)) modelMisses++;
      modelGhr = ((modelGhr * 2) + (taken ? 1 : 0)) % DEPTH;
   endtask

   // One cycle: drive at the falling edge, check lookup and counters before the
   // rising edge, then let the model consume the update at that rising edge.
   task automatic applyStimulus(input logic lv, input logic [31:0] pc, input logic [31:0] off,
                                input logic uv, input logic ut, input logic up,
                                input logic [IB-1:0] ui);
      int idx;
      @(negedge clk);
      lookupValid     = lv;
      lookupPc        = pc;
      lookupOffset    = off;
      updateValid     = uv;
      updateTaken     = ut;
      updatePredicted = up;
      updateIndex     = ui;
      #1;
      idx = modelIndex(pc);
      checkOutput("predicted", 32'(predicted), (lv && modelPht[idx] >= 2) ? 32'd1 : 32'd0);
      checkOutput("target", predictedTarget, pc + off);
      checkOutput("index", 32'(predictedIndex), 32'(idx));
      checkOutput("branch_count", branchCount, 32'(modelBranches));
      checkOutput("mispredict_count", mispredictCount, 32'(modelMisses));
      @(posedge clk);
      if (uv) modelUpdate(ut, up, int'(ui));
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      updateValid = 1'b0;
      #1;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      lookupValid = 1'b0;
      lookupPc    = '0;
      lookupOffset = '0;
      updateValid = 1'b0;
      updateTaken = 1'b0;
      updatePredicted = 1'b0;
      updateIndex = '0;
      modelReset();
      #12;
      @(negedge clk);
      rst_n = 1'b1;

      // Post-reset lookup: weak not-taken everywhere, counters idle.
      applyStimulus(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("reset_predicted", 32'(predicted), 32'd0);
      checkOutput("reset_index", 32'(predictedIndex), 32'h00);
      checkOutput("reset_branch_count", branchCount, 32'd0);
      checkOutput("reset_mispredict_count", mispredictCount, 32'd0);

      // Target wraps modulo 2^32 with a negative offset; invalid lookup never predicts.
      applyStimulus(1'b1, 32'h1000, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("target_negative_offset", predictedTarget, 32'h0000_0FF0);
      applyStimulus(1'b0, 32'h14, 32'h8, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("invalid_lookup", 32'(predicted), 32'd0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
      // Bimodal training of entry 5 (PC 0x14) through its saturation points.
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 6'd5);
      #1;
      checkOutput("bim_after_first_taken", 32'(predicted), 32'd1);
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b1, 1'b1, 6'd5);
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b1, 1'b1, 6'd5);
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5);
      #1;
      checkOutput("bim_one_not_taken", 32'(predicted), 32'd1);
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5);
      #1;
      checkOutput("bim_two_not_taken", 32'(predicted), 32'd0);
      // Same-cycle lookup and update of entry 5: old value seen, new value next cycle.
      applyStimulus(1'b1, 32'h14, 32'h0, 1'b1, 1'b1, 1'b0, 6'd5);
      #1;
      checkOutput("same_cycle_next", 32'(predicted), 32'd1);
`endif

      // Ten resolved branches, four mispredicted.
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, i[0], (i < 4) ? ~i[0] : i[0], IB'(i));
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("ten_branch_count", branchCount, 32'd10);
      checkOutput("four_mispredict_count", mispredictCount, 32'd4);

      // Counters preloaded to all ones must hold through further updates.
      @(negedge clk);
      force dut.r_branch_count = 32'hFFFF_FFFF;
      force dut.r_mispredict_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_branch_count;
      release dut.r_mispredict_count;
      modelBranches = MAXC;
      modelMisses   = MAXC;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd3);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("branch_count_saturated", branchCount, 32'hFFFF_FFFF);
      checkOutput("mispredict_count_saturated", mispredictCount, 32'hFFFF_FFFF);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
      // Two taken outcomes fill history with 2'b11, steering PC 0x100 to index 3.
      doReset();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd0);
      applyStimulus(1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      checkOutput("gshare_index", 32'(predictedIndex), 32'h03);
`endif

      // Randomized traffic on a small set of entries so updates and lookups collide.
      doReset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc;
         logic [IB-1:0] ui;
         logic ut;
         pc = $urandom;
         if ($urandom_range(0, 1) == 1) pc = {24'h0, 2'b00, 3'b000, 3'($urandom_range(0, 7))} << 2;
         ui = IB'($urandom_range(0, 7));
         ut = ($urandom_range(0, 3) != 0);
         applyStimulus(1'(($urandom_range(0, 3)) != 0), pc, $urandom,
                       1'(($urandom_range(0, 2)) != 0), ut, 1'($urandom_range(0, 1)), ui);
      end

      // Train entry 16 (PC 0x40 under bimodal), then assert reset between edges.
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd16);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 6'd16);
      @(negedge clk);
      lookupValid = 1'b1;
      lookupPc    = 32'h40;
      lookupOffset = 32'h0;
      updateValid = 1'b1;
      updateTaken = 1'b1;
      updatePredicted = 1'b0;
      updateIndex = 6'd16;
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset_predicted", 32'(predicted), 32'd0);
      checkOutput("async_reset_index", 32'(predictedIndex), 32'd16);
      checkOutput("async_reset_branch_count", branchCount, 32'd0);
      checkOutput("async_reset_mispredict_count", mispredictCount, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      updateValid = 1'b0;
      #1;
      checkOutput("lost_update_predicted", 32'(predicted), 32'd0);
      checkOutput("lost_update_branch_count", branchCount, 32'd0);
      applyStimulus(1'b1, 32'h40, 32'h4, 1'b1, 1'b1, 1'b1, 6'd16);
      applyStimulus(1'b1, 32'h40, 32'h4, 1'b0, 1'b0, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
